// File: rtl/fft_pkg.sv
// fft_pkg: constants and state encoding shared by the FFT core and its result streamer.
package fft_pkg;
    localparam int D_WIDTH     = 64;
    localparam int LOG_2_WIDTH = 6;
    localparam int SAMPLE_W    = 16;
    localparam int TIMER_W     = 10;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, STREAM} state_t;
endpackage

// File: rtl/fft_latency_timer.sv
// fft_latency_timer: loadable down-counter that stops at zero, plus a sticky pending-frame flag.
module fft_latency_timer
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    input  logic               set,
    input  logic               clr,
    output logic               zero,
    output logic               pending
);
    logic [TIMER_W-1:0] count_q, count_d;
    logic               pending_q, pending_d;

    assign zero    = count_q == '0;
    assign pending = pending_q;

    always_comb begin
        count_d   = load ? load_val : (en && !zero) ? count_q - 1'b1 : count_q;
        pending_d = clr ? 1'b0 : set ? 1'b1 : pending_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: rtl/fft_result_streamer.sv
// fft_result_streamer: snapshots the FFT core's result arrays a fixed latency after start
// and streams them out one bin per valid/ready handshake.
module fft_result_streamer
    import fft_pkg::*;
#(
    parameter int D_WIDTH     = fft_pkg::D_WIDTH,
    parameter int LOG_2_WIDTH = fft_pkg::LOG_2_WIDTH,
    parameter int SAMPLE_W    = fft_pkg::SAMPLE_W,
    parameter int FFT_LATENCY = 200
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fft_start,
    input  logic [D_WIDTH-1:0][SAMPLE_W-1:0] fft_re,
    input  logic [D_WIDTH-1:0][SAMPLE_W-1:0] fft_im,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [SAMPLE_W-1:0]              m_re,
    output logic [SAMPLE_W-1:0]              m_im,
    output logic [LOG_2_WIDTH-1:0]           m_index,
    output logic                             m_first,
    output logic                             m_last,
    output logic                             busy,
    output logic                             overrun
);
    localparam logic [TIMER_W-1:0]     LOAD_VAL = TIMER_W'(FFT_LATENCY - 1);
    localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);

    state_t                           state_q, state_d;
    logic [LOG_2_WIDTH-1:0]           ptr_q, ptr_d;
    logic [D_WIDTH-1:0][SAMPLE_W-1:0] re_q, re_d, im_q, im_d;
    logic                             overrun_q, overrun_d;
    logic                             zero, pending, hs, last_hs, set_pend, clr_pend;

    fft_latency_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (fft_start),
        .load_val (LOAD_VAL),
        .en       (busy),
        .set      (set_pend),
        .clr      (clr_pend),
        .zero     (zero),
        .pending  (pending)
    );

    assign m_valid = state_q == STREAM;
    assign busy    = state_q != IDLE;
    assign overrun = overrun_q;
    assign hs      = m_valid && m_ready;
    assign last_hs = hs && ptr_q == LAST_IDX;
    assign m_re    = m_valid ? re_q[ptr_q] : '0;
    assign m_im    = m_valid ? im_q[ptr_q] : '0;
    assign m_index = m_valid ? ptr_q : '0;
    assign m_first = m_valid && ptr_q == '0;
    assign m_last  = m_valid && ptr_q == LAST_IDX;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        re_d      = re_q;
        im_d      = im_q;
        overrun_d = 1'b0;
        set_pend  = 1'b0;
        clr_pend  = 1'b0;
        case (state_q)
            IDLE:    state_d = fft_start ? WAIT : IDLE;
            WAIT:    state_d = (!fft_start && zero) ? CAPTURE : WAIT;
            CAPTURE: begin
                re_d     = fft_re;
                im_d     = fft_im;
                ptr_d    = '0;
                state_d  = STREAM;
                set_pend = fft_start;
            end
            STREAM: begin
                ptr_d = hs ? ptr_q + 1'b1 : ptr_q;
                // A start on the final beat supersedes any older pending frame.
                if (last_hs) begin
                    clr_pend = 1'b1;
                    state_d  = fft_start ? WAIT : !pending ? IDLE : zero ? CAPTURE : WAIT;
                end else if (fft_start) begin
                    set_pend = 1'b1;
                end else if (pending && zero) begin
                    overrun_d = 1'b1;
                    clr_pend  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot buffer carries no reset; it is only read after a CAPTURE.
    always_ff @(posedge clk) begin
        re_q <= re_d;
        im_q <= im_d;
    end
endmodule
